param_timer_arbiter: RTL and testbench
======================================

# param_timer_arbiter

Shares one parameterized down-counter among `NREQ` requesters, each needing a one-shot timeout of its own length. The block arbitrates pending requests, loads the winner's count value, runs the counter to expiry and returns a single-cycle `done` pulse to the owner. It sits between several control FSMs and the counter resource, so one counter serves all of them.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `MOD`, default 40000: counter modulus. Counter width `W = $clog2(MOD)`. Largest usable load is `MOD-1`.

- `clk`  input  1  clock; all logic on its rising edge.
- `rst_`  input  1  reset, asynchronous, active-low.
- `req`  input  NREQ  level request per requester. The requester holds it until `done` is seen, or drops it to abort.
- `load`  input  NREQ*W  per-requester timeout value; requester i is at `[i*W +: W]`. Sampled only on the grant edge.
- `gnt`  output  NREQ  one-hot owner of the counter; all zero when idle.
- `done`  output  NREQ  one-cycle expiry pulse, asserted only on the owner's bit.
- `busy`  output  1  high in RUN and DONE.
- `cnt`  output  W  current counter value.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - If any `req` bit is set, select winner k (see Configuration), latch k and go to RUN.
  - Load `cnt` with `load[k]`. A load of 0 is treated as 1; a load above `MOD-1` is clamped to `MOD-1`.
- **RUN:**
  - `gnt[k]` is high. `cnt` decrements by 1 every cycle.
  - When `cnt==1`, the next state is DONE and `cnt` becomes 0.
- **DONE:**
  - `done[k]=1` and `gnt[k]=1` for exactly one cycle; `cnt=0`.
  - Next state is always IDLE.
- **Abort:** if `req[k]` is low in any RUN cycle, the next state is IDLE, `cnt` goes to 0 and no `done` is issued. Non-owner `req` changes never affect RUN.
- **Re-request:** `req` is not sampled in DONE. If the owner keeps `req` high into IDLE, it is treated as a new request and competes normally.
- The `load` of a non-winner is ignored. Changes to the owner's `load` after the grant edge are ignored.
- Reset (async assert, any state) takes effect immediately:
  - state = IDLE, `cnt=0`, `gnt=0`, `done=0`, `busy=0`.
  - Latched owner = 0; round-robin pointer = NREQ-1, so requester 0 has first priority.

## Timing
- Request with load L (L≥1), sampled in IDLE at edge t:
  - `gnt[k]` and `busy` rise after edge t, with `cnt=L`.
  - `cnt=1` after edge t+L-1.
  - `done[k]` is high after edge t+L; `gnt` and `busy` fall after edge t+L+1.
- Request to `done` latency = L+1 cycles. Counter occupancy = L+2 cycles including the return to IDLE.
- Minimum spacing between grants is L+2 cycles; back-to-back requests get no extra gap beyond the IDLE cycle.
- All outputs are registered. `done` never coincides with a `gnt` change of a different requester.
- Reset deassertion: the first edge with `rst_` high may sample `req`.

## Configuration
- Macro `PARAM_TIMER_RR_EN`:
  - **Defined:** round-robin arbitration. Search starts at (last owner + 1) mod NREQ. The pointer updates on every grant, including grants later aborted.
  - **Undefined:** fixed priority; the lowest-index pending `req` wins and no pointer is kept.
- Port list and timing are identical in both builds.

## Test plan
- **Single timer.** After reset, `req[2]=1` with `load[2]=5`.
  - `gnt=4'b0100` with `cnt` 5,4,3,2,1, then `done=4'b0100` for one cycle with `cnt=0`, then `gnt=0`.
  - `done` arrives 6 cycles after the request edge.
- **Edge loads.** `load=0` gives `done` 2 cycles after grant, same as `load=1`. `load=MOD+7` (MOD=40000) gives `cnt=39999` on grant.
- **Contention.** `req=4'b1111` held high, all loads 2.
  - With RR: grant order 0,1,2,3,0.
  - Without RR: grant order 0,0,0.
  - 4 cycles between successive grant edges in both builds.
- **Abort.** `req[1]` granted with load 10, dropped when `cnt=6`. Next cycle is IDLE with `cnt=0`, no `done` pulse; a pending `req[3]` is granted one cycle later.
- **Reset mid-count.** `rst_` pulled low asynchronously with `cnt=17`. `gnt`, `done`, `busy` and `cnt` go to 0 without waiting for a clock edge; after release, `req=4'b1000` is granted normally.
- **Held request.** Owner keeps `req[0]` high through `done`. It is re-granted on the IDLE edge when alone, or loses to the RR-next requester when others are pending (RR build).

Source files
------------

// File: rtl/param_timer_arbiter.sv
// rtl/param_timer_arbiter.sv - one shared down-counter arbitrated among NREQ one-shot timer requesters
//
// Purpose: NREQ requesters share one down-counter. A pending request wins
// arbitration in IDLE. Its timeout is loaded and counted down to expiry.
// The owner then gets a single-cycle done pulse.
// Build option: define PARAM_TIMER_RR_EN for round-robin arbitration.
// When it is undefined, arbitration is fixed priority (lowest index wins).
//
// Ports:
//   clk   in   1       clock, rising edge
//   rst_  in   1       asynchronous active-low reset
//   req   in   NREQ    level request per requester (drop to abort)
//   load  in   NREQ*W  per-requester timeout, requester i at [i*W +: W]
//   gnt   out  NREQ    one-hot owner of the counter, zero when idle
//   done  out  NREQ    one-cycle expiry pulse on the owner's bit
//   busy  out  1       high while the counter is owned (RUN and DONE)
//   cnt   out  W       current counter value

module param_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int MOD  = 40000,
   localparam int W   = $clog2(MOD)
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] load,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [W-1:0]      cnt
);

   localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [W-1:0]  CNT_MAX = W'(MOD - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   owner, owner_n;
   logic [W-1:0]    cnt_n;
   logic [NREQ-1:0] gnt_n, done_n, owner_oh;
   logic            busy_n;
   logic [IW-1:0]   win, idx;
   logic            win_valid;
   logic [W-1:0]    win_load, load_eff;
`ifdef PARAM_TIMER_RR_EN
   logic [IW-1:0]   ptr, ptr_n;
`endif

   // Arbitration: only consumed in IDLE.
   always_comb begin
      win       = '0;
      win_valid = 1'b0;
      idx       = '0;
`ifdef PARAM_TIMER_RR_EN
      // Search starts one past the last owner and wraps around.
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(ptr) + i) % NREQ);
         if (!win_valid && req[idx]) begin
            win       = idx;
            win_valid = 1'b1;
         end
      end
`else
      // Scan downward so the lowest pending index is the last to overwrite.
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IW'(i);
         if (req[idx]) begin
            win       = idx;
            win_valid = 1'b1;
         end
      end
`endif
   end

   // Winner's load, with 0 promoted to 1 and oversize values clamped.
   always_comb begin
      win_load = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) win_load = load[i*W +: W];
      end
      if (win_load == '0)          load_eff = W'(1);
      else if (win_load > CNT_MAX) load_eff = CNT_MAX;
      else                         load_eff = win_load;
   end

   assign owner_oh = NREQ'(1) << owner;

   always_comb begin
      state_n = state;
      owner_n = owner;
      cnt_n   = cnt;
      gnt_n   = '0;
      done_n  = '0;
      busy_n  = 1'b0;
`ifdef PARAM_TIMER_RR_EN
      ptr_n   = ptr;
`endif
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (win_valid) begin
               state_n = RUN;
               owner_n = win;
               cnt_n   = load_eff;
               gnt_n   = NREQ'(1) << win;
               busy_n  = 1'b1;
`ifdef PARAM_TIMER_RR_EN
               ptr_n   = win;
`endif
            end
         end
         RUN: begin
            // An owner dropping its request beats expiry in the same cycle.
            if (!req[owner]) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == W'(1)) begin
               state_n = DONE;
               cnt_n   = '0;
               gnt_n   = owner_oh;
               done_n  = owner_oh;
               busy_n  = 1'b1;
            end else begin
               cnt_n   = cnt - W'(1);
               gnt_n   = owner_oh;
               busy_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
         owner <= '0;
         cnt   <= '0;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
`ifdef PARAM_TIMER_RR_EN
         ptr   <= IW'(NREQ - 1);
`endif
      end else begin
         state <= state_n;
         owner <= owner_n;
         cnt   <= cnt_n;
         gnt   <= gnt_n;
         done  <= done_n;
         busy  <= busy_n;
`ifdef PARAM_TIMER_RR_EN
         ptr   <= ptr_n;
`endif
      end
   end

endmodule

// File: tb/tb_param_timer_arbiter.sv
// tb/tb_param_timer_arbiter.sv - self-checking bench for param_timer_arbiter

module tb_param_timer_arbiter;

   localparam int NREQ = 4;
   localparam int MOD  = 40000;
   localparam int W    = $clog2(MOD);

   logic              clk = 1'b0;
   logic              rst_;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] load;
   logic [NREQ-1:0]   gnt, done;
   logic              busy;
   logic [W-1:0]      cnt;
   logic [W-1:0]      ld [NREQ];

   int checks = 0;
   int errors = 0;

   param_timer_arbiter #(.NREQ(NREQ), .MOD(MOD)) dut (
      .clk(clk), .rst_(rst_), .req(req), .load(load),
      .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      load = '0;
      for (int i = 0; i < NREQ; i++) load[i*W +: W] = ld[i];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b0;
      req  = '0;
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit m_active;
   int m_own, m_len, m_age, m_ptr;

   function automatic int eff_load(input int v);
      if (v == 0) return 1;
      if (v > MOD - 1) return MOD - 1;
      return v;
   endfunction

   function automatic int pick(input int rm);
`ifdef PARAM_TIMER_RR_EN
      for (int off = 1; off <= NREQ; off++) begin
         int i;
         i = (m_ptr + off) % NREQ;
         if (((rm >> i) & 1) != 0) return i;
      end
`else
      for (int i = 0; i < NREQ; i++)
         if (((rm >> i) & 1) != 0) return i;
`endif
      return -1;
   endfunction

   // m_age = edges since the grant edge; the timer expires at age m_len.
   task automatic model_edge(input int rm);
      if (!m_active) begin
         if (rm != 0) begin
            m_own    = pick(rm);
            m_len    = eff_load(int'(ld[m_own]));
            m_age    = 0;
            m_ptr    = m_own;
            m_active = 1'b1;
         end
      end else if (m_age == m_len) begin
         m_active = 1'b0;
      end else if (((rm >> m_own) & 1) == 0) begin
         m_active = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   function automatic logic [63:0] model_out();
      logic [NREQ-1:0] g, d;
      logic            b;
      logic [W-1:0]    c;
      g = '0; d = '0; b = 1'b0; c = '0;
      if (m_active) begin
         g = NREQ'(1) << m_own;
         b = 1'b1;
         if (m_age == m_len) d = g;
         else c = W'(m_len - m_age);
      end
      return 64'({g, d, b, c});
   endfunction

   // ---------------- table-driven single-timer vectors ----------------
   typedef struct {
      int k;
      int ldv;
      int exp_cnt;
      int exp_lat;
      bit run_out;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NREQ-1:0] oh, prev_g;
      int lat, exp_c, ng, k, rm;
      int gidx [5];
      int gstep [5];
      int exp_order [5];

      vecs[0] = '{2, 5,      5,     6,  1'b1};
      vecs[1] = '{0, 0,      1,     2,  1'b1};
      vecs[2] = '{1, 1,      1,     2,  1'b1};
      vecs[3] = '{3, 3,      3,     4,  1'b1};
      vecs[4] = '{1, 40007,  39999, 0,  1'b0};
      vecs[5] = '{3, 65535,  39999, 0,  1'b0};
      vecs[6] = '{0, 39999,  39999, 0,  1'b0};
      vecs[7] = '{2, 12,     12,    13, 1'b1};

      rst_ = 1'b0;
      req  = '0;
      for (int i = 0; i < NREQ; i++) ld[i] = '0;
      repeat (2) @(negedge clk);
      check("reset_gnt",  64'(gnt),  64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_cnt",  64'(cnt),  64'(0));
      rst_ = 1'b1;

      // Single requests, one at a time
      for (int v = 0; v < NV; v++) begin
         k  = vecs[v].k;
         oh = NREQ'(1) << k;
         for (int i = 0; i < NREQ; i++) ld[i] = W'($urandom_range(0, 65535));
         ld[k] = W'(vecs[v].ldv);
         req   = oh;
         step();
         lat = 1;
         check("vec_gnt",  64'(gnt),  64'(oh));
         check("vec_cnt0", 64'(cnt),  64'(vecs[v].exp_cnt));
         check("vec_busy", 64'(busy), 64'(1));
         ld[k] = W'($urandom_range(0, 65535));
         if (vecs[v].run_out) begin
            exp_c = vecs[v].exp_cnt;
            while (done == '0 && lat < 200) begin
               check("vec_cnt_seq", 64'(cnt), 64'(exp_c));
               step();
               lat++;
               exp_c--;
            end
            check("vec_latency", 64'(lat),  64'(vecs[v].exp_lat));
            check("vec_done",    64'(done), 64'(oh));
            check("vec_done_gnt",64'(gnt),  64'(oh));
            check("vec_done_cnt",64'(cnt),  64'(0));
            req = '0;
            step();
            check("vec_after_done", 64'({gnt, done, busy}), 64'(0));
         end else begin
            req = '0;
            step();
            check("vec_abort_idle", 64'({gnt, done, busy, cnt}), 64'(0));
         end
         step();
      end

      // Contention: all four held high, loads 2
      do_reset();
      for (int i = 0; i < NREQ; i++) ld[i] = W'(2);
      req    = '1;
      prev_g = '0;
      ng     = 0;
      for (int c = 1; c <= 60 && ng < 5; c++) begin
         step();
         if (gnt != '0 && prev_g == '0) begin
            for (int i = 0; i < NREQ; i++) if (gnt == (NREQ'(1) << i)) gidx[ng] = i;
            gstep[ng] = c;
            ng++;
         end
         prev_g = gnt;
      end
      check("cont_grants", 64'(ng), 64'(5));
`ifdef PARAM_TIMER_RR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif
      for (int i = 0; i < 5 && i < ng; i++) begin
         check("cont_order", 64'(gidx[i]), 64'(exp_order[i]));
         if (i > 0) check("cont_spacing", 64'(gstep[i] - gstep[i-1]), 64'(4));
      end
      req = '0;
      repeat (4) step();

      // Abort: owner 1 drops at cnt=6 while 3 waits
      do_reset();
      ld[1] = W'(10);
      ld[3] = W'(3);
      req   = 4'b1010;
      step();
      check("abort_gnt", 64'(gnt), 64'(4'b0010));
      check("abort_cnt", 64'(cnt), 64'(10));
      lat = 0;
      while (cnt != W'(6) && lat < 20) begin
         step();
         lat++;
      end
      check("abort_reach6", 64'(cnt), 64'(6));
      req = 4'b1000;
      step();
      check("abort_idle", 64'({gnt, done, busy, cnt}), 64'(0));
      step();
      check("abort_next_gnt", 64'(gnt), 64'(4'b1000));
      check("abort_next_cnt", 64'(cnt), 64'(3));
      req = '0;
      repeat (2) step();

      // Asynchronous reset in the middle of a count
      do_reset();
      ld[0] = W'(30);
      req   = 4'b0001;
      step();
      lat = 0;
      while (cnt != W'(17) && lat < 40) begin
         step();
         lat++;
      end
      check("rst_reach17", 64'(cnt), 64'(17));
      #2 rst_ = 1'b0;
      #1;
      check("rst_async", 64'({gnt, done, busy, cnt}), 64'(0));
      @(negedge clk);
      rst_  = 1'b1;
      ld[3] = W'(4);
      req   = 4'b1000;
      step();
      check("rst_after_gnt", 64'(gnt), 64'(4'b1000));
      check("rst_after_cnt", 64'(cnt), 64'(4));
      req = '0;
      repeat (2) step();

      // Held request: owner keeps req high through done
      do_reset();
      ld[0] = W'(2);
      ld[1] = W'(3);
      req   = 4'b0001;
      step();
      check("held_gnt", 64'(gnt), 64'(4'b0001));
      repeat (2) step();
      check("held_done", 64'(done), 64'(4'b0001));
      step();
      check("held_idle", 64'({gnt, busy}), 64'(0));
      step();
      check("held_regrant", 64'(gnt), 64'(4'b0001));
      check("held_regrant_cnt", 64'(cnt), 64'(2));
      req = 4'b0011;
      repeat (2) step();
      check("held_done2", 64'(done), 64'(4'b0001));
      repeat (2) step();
`ifdef PARAM_TIMER_RR_EN
      check("held_contend_gnt", 64'(gnt), 64'(4'b0010));
      check("held_contend_cnt", 64'(cnt), 64'(3));
`else
      check("held_contend_gnt", 64'(gnt), 64'(4'b0001));
      check("held_contend_cnt", 64'(cnt), 64'(2));
`endif
      req = '0;
      repeat (2) step();

      // Randomized run against the reference model
      do_reset();
      m_active = 1'b0;
      m_own    = 0;
      m_ptr    = NREQ - 1;
      for (int c = 0; c < 2000; c++) begin
         check("rand_outputs", 64'({gnt, done, busy, cnt}), model_out());
         for (int i = 0; i < NREQ; i++) ld[i] = W'($urandom_range(0, 9));
         rm = 0;
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 99) < 40) rm = rm | (1 << i);
         if (m_active) begin
            if ($urandom_range(0, 99) < 92) rm = rm | (1 << m_own);
            else rm = rm & ~(1 << m_own);
         end
         req = NREQ'(rm);
         model_edge(rm);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
